// File: rtl/pipe_reg_em_pkg.sv
// Shared constants for the E/M pipeline register: reset PC, link offset,
// Tnew width and the nop encoding.
package pipe_reg_em_pkg;

  localparam int unsigned TNEW_W       = 2;
  localparam int unsigned REG_W        = 5;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam int unsigned LINK_OFS_DEF = 8;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

endpackage

// File: rtl/pipe_reg_em_if.sv
// E-side inputs and M-side outputs of the E/M register, bundled with
// master (E stage / driver) and slave (register) views.
interface pipe_reg_em_if
  import pipe_reg_em_pkg::*;
#(
  parameter int unsigned DW = 32
) ();

  logic              en;
  logic              clr;
  logic [31:0]       Instr_E;
  logic [DW-1:0]     PC_E;
  logic [DW-1:0]     ALUOut_E;
  logic [DW-1:0]     RtData_E;
  logic [REG_W-1:0]  E_RFDst;
  logic [TNEW_W-1:0] Tnew_E;
  logic              isjal_E;

  logic [31:0]       Instr_M;
  logic [DW-1:0]     PC_M;
  logic [DW-1:0]     ALUOut_M;
  logic [DW-1:0]     WD_M;
  logic [REG_W-1:0]  M_RFDst;
  logic [TNEW_W-1:0] Tnew_M;
  logic              isjal_M;
  logic [DW-1:0]     FwdData_M;
  logic              valid_M;

  modport master (
    output en, clr, Instr_E, PC_E, ALUOut_E, RtData_E, E_RFDst, Tnew_E, isjal_E,
    input  Instr_M, PC_M, ALUOut_M, WD_M, M_RFDst, Tnew_M, isjal_M, FwdData_M, valid_M
  );

  modport slave (
    input  en, clr, Instr_E, PC_E, ALUOut_E, RtData_E, E_RFDst, Tnew_E, isjal_E,
    output Instr_M, PC_M, ALUOut_M, WD_M, M_RFDst, Tnew_M, isjal_M, FwdData_M, valid_M
  );

endinterface

// File: rtl/pipe_reg_em_field_reg.sv
// One pipeline field: async active-low reset, clr loads the bubble value
// (which equals the reset value), en loads new data, otherwise hold.
module pipe_field_reg #(
  parameter int unsigned W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= RST_VAL;
    end else if (clr_i) begin
      data_q <= RST_VAL;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipe_reg_em.sv
// E/M pipeline register of the 5-stage MIPS core. Define
// PIPE_EM_BUBBLE_CNT_EN to add a saturating bubble_cnt output.
module pipe_reg_em
  import pipe_reg_em_pkg::*;
#(
  parameter int unsigned    DW       = 32,
  parameter logic [DW-1:0]  RESET_PC = DW'(RESET_PC_DEF),
  parameter int unsigned    LINK_OFS = LINK_OFS_DEF
) (
  input  logic         clk,
  input  logic         reset,
  pipe_reg_em_if.slave bus
`ifdef PIPE_EM_BUBBLE_CNT_EN
  ,
  output logic [31:0]  bubble_cnt
`endif
);

  logic [TNEW_W-1:0] tnew_d;

  // Tnew counts down one stage per hop but never wraps below zero
  always_comb begin
    tnew_d = '0;
    if (bus.Tnew_E != '0) begin
      tnew_d = bus.Tnew_E - TNEW_W'(1);
    end
  end

  pipe_field_reg #(.W(32), .RST_VAL(NOP_INSTR)) u_instr (
    .clk(clk), .reset(reset), .clr_i(bus.clr), .en_i(bus.en),
    .d_i(bus.Instr_E), .q_o(bus.Instr_M)
  );

  pipe_field_reg #(.W(DW), .RST_VAL(RESET_PC)) u_pc (
    .clk(clk), .reset(reset), .clr_i(bus.clr), .en_i(bus.en),
    .d_i(bus.PC_E), .q_o(bus.PC_M)
  );

  pipe_field_reg #(.W(DW), .RST_VAL('0)) u_alu (
    .clk(clk), .reset(reset), .clr_i(bus.clr), .en_i(bus.en),
    .d_i(bus.ALUOut_E), .q_o(bus.ALUOut_M)
  );

  pipe_field_reg #(.W(DW), .RST_VAL('0)) u_wd (
    .clk(clk), .reset(reset), .clr_i(bus.clr), .en_i(bus.en),
    .d_i(bus.RtData_E), .q_o(bus.WD_M)
  );

  pipe_field_reg #(.W(REG_W), .RST_VAL('0)) u_dst (
    .clk(clk), .reset(reset), .clr_i(bus.clr), .en_i(bus.en),
    .d_i(bus.E_RFDst), .q_o(bus.M_RFDst)
  );

  pipe_field_reg #(.W(TNEW_W), .RST_VAL('0)) u_tnew (
    .clk(clk), .reset(reset), .clr_i(bus.clr), .en_i(bus.en),
    .d_i(tnew_d), .q_o(bus.Tnew_M)
  );

  pipe_field_reg #(.W(1), .RST_VAL(1'b0)) u_jal (
    .clk(clk), .reset(reset), .clr_i(bus.clr), .en_i(bus.en),
    .d_i(bus.isjal_E), .q_o(bus.isjal_M)
  );

  // Every load from E is a real instruction, nop words included
  pipe_field_reg #(.W(1), .RST_VAL(1'b0)) u_valid (
    .clk(clk), .reset(reset), .clr_i(bus.clr), .en_i(bus.en),
    .d_i(1'b1), .q_o(bus.valid_M)
  );

  assign bus.FwdData_M = bus.isjal_M ? (bus.PC_M + DW'(LINK_OFS)) : bus.ALUOut_M;

`ifdef PIPE_EM_BUBBLE_CNT_EN
  logic [31:0] bubbleCnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubbleCnt_q <= '0;
    end else if (bus.clr && (bubbleCnt_q != 32'hFFFF_FFFF)) begin
      bubbleCnt_q <= bubbleCnt_q + 32'd1;
    end
  end

  assign bubble_cnt = bubbleCnt_q;
`endif

endmodule

// File: tb/tb_pipe_reg_em.sv
// Directed self-checking bench for pipe_reg_em; also covers bubble_cnt
// when built with PIPE_EM_BUBBLE_CNT_EN.
module tb_pipe_reg_em;

  logic clk;
  logic reset;
  int   passCount;
  int   checkCount;

  pipe_reg_em_if #(.DW(32)) bus ();

`ifdef PIPE_EM_BUBBLE_CNT_EN
  logic [31:0] bubbleCnt;
`endif

  pipe_reg_em dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef PIPE_EM_BUBBLE_CNT_EN
    ,
    .bubble_cnt(bubbleCnt)
`endif
  );

  localparam logic [136:0] BUBBLE = {32'h0, 32'h0000_3000, 32'h0, 32'h0, 5'd0, 2'd0, 1'b0, 1'b0};

  logic [136:0] snapM;
  assign snapM = {bus.Instr_M, bus.PC_M, bus.ALUOut_M, bus.WD_M,
                  bus.M_RFDst, bus.Tnew_M, bus.isjal_M, bus.valid_M};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic driveE(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] alu, input logic [31:0] rt,
                        input logic [4:0] dst, input logic [1:0] tnew,
                        input logic jal);
    bus.Instr_E  = instr;
    bus.PC_E     = pc;
    bus.ALUOut_E = alu;
    bus.RtData_E = rt;
    bus.E_RFDst  = dst;
    bus.Tnew_E   = tnew;
    bus.isjal_E  = jal;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.en = 1'b1;
    bus.clr = 1'b0;
    driveE($urandom, $urandom, $urandom, $urandom, 5'($urandom), 2'($urandom), 1'($urandom));
    step();
    step();
    bus.en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkCount++; if (snapM !== BUBBLE) $display("[TB] FAIL reset_fields got %h exp %h", snapM, BUBBLE); else passCount++;
    checkCount++; if (bus.PC_M !== 32'h0000_3000) $display("[TB] FAIL reset_pc got %h exp %h", bus.PC_M, 32'h3000); else passCount++;
    checkCount++; if (bus.FwdData_M !== 32'h0) $display("[TB] FAIL reset_fwd got %h exp %h", bus.FwdData_M, 32'h0); else passCount++;
`ifdef PIPE_EM_BUBBLE_CNT_EN
    checkCount++; if (bubbleCnt !== 32'd0) $display("[TB] FAIL reset_bcnt got %0d exp 0", bubbleCnt); else passCount++;
`endif
  endtask

  task automatic test_load();
    driveE(32'h0123_4567, 32'h0000_3004, 32'h0000_1234, 32'h0000_5678, 5'd5, 2'd2, 1'b0);
    bus.en = 1'b1;
    step();
    checkCount++; if (bus.ALUOut_M !== 32'h1234) $display("[TB] FAIL load_alu got %h exp %h", bus.ALUOut_M, 32'h1234); else passCount++;
    checkCount++; if (bus.WD_M !== 32'h5678) $display("[TB] FAIL load_wd got %h exp %h", bus.WD_M, 32'h5678); else passCount++;
    checkCount++; if (bus.PC_M !== 32'h3004) $display("[TB] FAIL load_pc got %h exp %h", bus.PC_M, 32'h3004); else passCount++;
    checkCount++; if (bus.Instr_M !== 32'h0123_4567) $display("[TB] FAIL load_instr got %h exp %h", bus.Instr_M, 32'h01234567); else passCount++;
    checkCount++; if (bus.M_RFDst !== 5'd5) $display("[TB] FAIL load_dst got %0d exp 5", bus.M_RFDst); else passCount++;
    checkCount++; if (bus.Tnew_M !== 2'd1) $display("[TB] FAIL load_tnew got %0d exp 1", bus.Tnew_M); else passCount++;
    checkCount++; if (bus.FwdData_M !== 32'h1234) $display("[TB] FAIL load_fwd got %h exp %h", bus.FwdData_M, 32'h1234); else passCount++;
    checkCount++; if (bus.valid_M !== 1'b1) $display("[TB] FAIL load_valid got %b exp 1", bus.valid_M); else passCount++;
  endtask

  task automatic test_link();
    driveE(32'h0C00_0C00, 32'h0000_3010, 32'hDEAD_BEEF, 32'h0, 5'd31, 2'd1, 1'b1);
    step();
    checkCount++; if (bus.Tnew_M !== 2'd0) $display("[TB] FAIL link_tnew got %0d exp 0", bus.Tnew_M); else passCount++;
    checkCount++; if (bus.isjal_M !== 1'b1) $display("[TB] FAIL link_jal got %b exp 1", bus.isjal_M); else passCount++;
    checkCount++; if (bus.M_RFDst !== 5'd31) $display("[TB] FAIL link_dst got %0d exp 31", bus.M_RFDst); else passCount++;
    checkCount++; if (bus.FwdData_M !== 32'h3018) $display("[TB] FAIL link_fwd got %h exp %h", bus.FwdData_M, 32'h3018); else passCount++;
    driveE(32'h0C00_0C00, 32'hFFFF_FFFC, 32'h1111_1111, 32'h0, 5'd31, 2'd1, 1'b1);
    step();
    checkCount++; if (bus.FwdData_M !== 32'h4) $display("[TB] FAIL link_wrap got %h exp %h", bus.FwdData_M, 32'h4); else passCount++;
  endtask

  task automatic test_tnew_sat();
    driveE(32'h0, 32'h0000_3020, 32'h0000_00AA, 32'h0, 5'd0, 2'd0, 1'b0);
    step();
    checkCount++; if (bus.Tnew_M !== 2'd0) $display("[TB] FAIL sat_tnew0 got %0d exp 0", bus.Tnew_M); else passCount++;
    checkCount++; if (bus.valid_M !== 1'b1) $display("[TB] FAIL sat_nopvalid got %b exp 1", bus.valid_M); else passCount++;
    checkCount++; if (bus.M_RFDst !== 5'd0) $display("[TB] FAIL sat_dst0 got %0d exp 0", bus.M_RFDst); else passCount++;
    driveE(32'h1, 32'h0000_3024, 32'h0, 32'h0, 5'd7, 2'd3, 1'b0);
    step();
    checkCount++; if (bus.Tnew_M !== 2'd2) $display("[TB] FAIL sat_tnew3 got %0d exp 2", bus.Tnew_M); else passCount++;
  endtask

  task automatic test_hold();
    logic [136:0] held;
    driveE(32'h2222_2222, 32'h0000_3030, 32'h0000_AAAA, 32'h0000_BBBB, 5'd9, 2'd2, 1'b0);
    step();
    held = {32'h2222_2222, 32'h0000_3030, 32'h0000_AAAA, 32'h0000_BBBB, 5'd9, 2'd1, 1'b0, 1'b1};
    bus.en = 1'b0;
    driveE(32'h3333_3333, 32'h0000_4000, 32'h0000_CCCC, 32'h0000_DDDD, 5'd3, 2'd3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      checkCount++; if (bus.Tnew_M !== 2'd1) $display("[TB] FAIL hold_tnew edge %0d got %0d exp 1", i, bus.Tnew_M); else passCount++;
    end
    checkCount++; if (snapM !== held) $display("[TB] FAIL hold_fields got %h exp %h", snapM, held); else passCount++;
  endtask

  task automatic test_priority();
    bus.en = 1'b1;
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    checkCount++; if (snapM !== BUBBLE) $display("[TB] FAIL prio_clr_en got %h exp %h", snapM, BUBBLE); else passCount++;
    checkCount++; if (bus.FwdData_M !== 32'h0) $display("[TB] FAIL prio_fwd got %h exp 0", bus.FwdData_M); else passCount++;
    driveE(32'h4444_4444, 32'h0000_3040, 32'h0000_0040, 32'h0, 5'd4, 2'd2, 1'b0);
    step();
    checkCount++; if (bus.valid_M !== 1'b1) $display("[TB] FAIL prio_reload got %b exp 1", bus.valid_M); else passCount++;
    bus.en = 1'b0;
    bus.clr = 1'b1;
    step();
    checkCount++; if (snapM !== BUBBLE) $display("[TB] FAIL prio_clr_stall got %h exp %h", snapM, BUBBLE); else passCount++;
    step();
    bus.clr = 1'b0;
`ifdef PIPE_EM_BUBBLE_CNT_EN
    checkCount++; if (bubbleCnt !== 32'd3) $display("[TB] FAIL bubble_cnt got %0d exp 3", bubbleCnt); else passCount++;
`endif
  endtask

  task automatic test_async_reset();
    driveE(32'h5555_5555, 32'h0000_3050, 32'h0000_0050, 32'h0000_0051, 5'd12, 2'd2, 1'b1);
    bus.en = 1'b1;
    step();
    bus.en = 1'b0;
    checkCount++; if (bus.valid_M !== 1'b1) $display("[TB] FAIL async_pre got %b exp 1", bus.valid_M); else passCount++;
    #2;
    reset = 1'b0;
    #1;
    checkCount++; if (snapM !== BUBBLE) $display("[TB] FAIL async_clear got %h exp %h", snapM, BUBBLE); else passCount++;
    checkCount++; if (bus.FwdData_M !== 32'h0) $display("[TB] FAIL async_fwd got %h exp 0", bus.FwdData_M); else passCount++;
`ifdef PIPE_EM_BUBBLE_CNT_EN
    checkCount++; if (bubbleCnt !== 32'd0) $display("[TB] FAIL async_bcnt got %0d exp 0", bubbleCnt); else passCount++;
`endif
    @(negedge clk);
    reset = 1'b1;
    bus.en = 1'b1;
    step();
    checkCount++; if (bus.ALUOut_M !== 32'h50) $display("[TB] FAIL async_recover got %h exp %h", bus.ALUOut_M, 32'h50); else passCount++;
  endtask

  initial begin
    passCount  = 0;
    checkCount = 0;
    test_reset();
    test_load();
    test_link();
    test_tnew_sat();
    test_hold();
    test_priority();
    test_async_reset();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pipe_reg_em.md
Name: pipe_reg_em

Overview:
- E/M pipeline register of the 5-stage MIPS core.
- Captures the E-stage results: the ALU result, the forwarded store data, PC, the instruction, and the E-controller decode (destination register, Tnew, link flag). Presents them to the M stage.
- Generates the M-stage forwarding value and decrements Tnew for the hazard unit.
- Supports bubble insertion (clear) and hold (stall).

Parameters:
- DW, 32, datapath width.
- RESET_PC, 32'h0000_3000, PC_M value after reset or bubble.
- LINK_OFS, 8, offset added to PC_E to form the link address for jal/jalr.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous reset, active-low; the register state is reset while reset==0.
- en  in  1  1 = load from E; 0 = hold current contents.
- clr  in  1  1 = load a bubble on the next edge; clr has priority over en.
- Instr_E  in  32  instruction word in E.
- PC_E  in  DW  PC of the instruction in E.
- ALUOut_E  in  DW  ALU result.
- RtData_E  in  DW  forwarded rt value, used as sw store data.
- E_RFDst  in  5  destination register from the E controller (0 = none).
- Tnew_E  in  2  cycles until the result is ready, as seen in E.
- isjal_E  in  1  instruction is jal/jalr.
- Instr_M  out  32  registered instruction.
- PC_M  out  DW  registered PC.
- ALUOut_M  out  DW  registered ALU result (memory address for lw/sw).
- WD_M  out  DW  registered store data.
- M_RFDst  out  5  registered destination register.
- Tnew_M  out  2  registered Tnew, already decremented.
- isjal_M  out  1  registered link flag.
- FwdData_M  out  DW  combinational: PC_M+LINK_OFS if isjal_M, else ALUOut_M.
- valid_M  out  1  1 = real instruction; 0 = bubble.

Behaviour:
- All state is in flops on the rising edge of clk. reset==0 clears them asynchronously, independent of clk.
- Reset / bubble values:
  - Instr_M=0 (nop), PC_M=RESET_PC.
  - ALUOut_M=0, WD_M=0, M_RFDst=0, Tnew_M=0, isjal_M=0, valid_M=0.
  - Consequently FwdData_M=0 after reset (isjal_M=0, ALUOut_M=0).
- Edge priority:
  1. reset low: asynchronous reset.
  2. clr=1: load bubble values.
  3. en=1: load from E.
  4. Otherwise: hold all fields.
- clr=1 with en=0 loads a bubble; a flush overrides a stall.
- Latency: one cycle. Values sampled at edge k appear on the outputs immediately after edge k.
- Tnew_M on a load:
  - Tnew_M = Tnew_E-1 when Tnew_E>0; Tnew_M=0 when Tnew_E==0 (saturating at 0).
  - The value 2'b11 maps to 2'b10. No wrap-around is permitted.
- While holding (en=0, clr=0), Tnew_M is NOT decremented again; it holds.
- M_RFDst is loaded unmodified, including 0. Consumers ignore destination 0; this block does not gate it.
- valid_M=1 on every load from E, including nop words. It is 0 only after reset or clr.
- FwdData_M is purely combinational from the registered fields. There is no extra cycle of latency.
- PC_M+LINK_OFS is computed modulo 2^DW; the carry is discarded.
- Reset deasserting mid-cycle: the flops take effect from the next rising edge.

Optional Feature:
- Macro: PIPE_EM_BUBBLE_CNT_EN.
- When defined:
  - Extra output bubble_cnt [31:0].
  - Increments on each edge where clr=1 (reset low has priority). Saturates at 32'hFFFF_FFFF.
  - Reset value 0.
- When undefined: the port and counter are absent, and all other behaviour is identical.

Decomposition:
- Shared package/header holds:
  - RESET_PC default.
  - LINK_OFS default.
  - The Tnew width constant (2).
  - The NOP encoding (32'h0).
- One natural sub-module: pipe_field_reg, a DW-parameterised register with async active-low reset, clr and en. It is instantiated once per field.
- The Tnew decrement and the FwdData mux stay in the top module.

Test Plan:
- Reset: drive reset=0 with random inputs, then reset=1 with no clk edge → all outputs hold their reset values, including PC_M=32'h3000 and valid_M=0.
- Load: ALUOut_E=32'h1234, E_RFDst=5, Tnew_E=2, isjal_E=0, en=1, one edge → ALUOut_M=32'h1234, M_RFDst=5, Tnew_M=1, FwdData_M=32'h1234, valid_M=1.
- Link: PC_E=32'h3010, isjal_E=1, E_RFDst=31, Tnew_E=1 → Tnew_M=0, FwdData_M=32'h3018. Repeat with PC_E=32'hFFFF_FFFC → FwdData_M=32'h4 (wrap).
- Tnew saturation: Tnew_E=0 → Tnew_M=0. Hold: en=0 for 3 edges after loading Tnew_E=2 → Tnew_M stays 1 and all fields are unchanged.
- Priority: clr=1 and en=1 on the same edge → bubble values. clr=1 with en=0 → bubble. With PIPE_EM_BUBBLE_CNT_EN defined, 3 clr edges → bubble_cnt=3.
- Async reset mid-stream: pull reset low between edges while a valid instruction is held → outputs clear immediately, without waiting for clk.
